// File: rtl/axi4_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_sram_responder_pkg
// Description : Shared AXI4 encodings and FSM states for the SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_sram_responder_pkg;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [2:0] c_SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RWAIT = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    function automatic logic [1:0] f_resp(input logic err);
        return err ? c_RESP_SLVERR : c_RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_sram_responder_if
// Description : AXI4 AR/R/AW/W/B channel bundle with initiator/responder views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_sram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid, rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rid, rlast, rvalid,
        input  awready, wready, bresp, bid, bvalid
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid, rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rid, rlast, rvalid,
        output awready, wready, bresp, bid, bvalid
    );

endinterface
`default_nettype wire

// File: rtl/axi4_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : axi4_sram_array
// Description : Single-port word SRAM, 1-cycle synchronous read, byte-lane writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_sram_array #(
    parameter int MEM_WORDS = 65536,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    // No reset: contents and the read register survive responder resets.
    always_ff @(posedge clk) begin
        if (re) begin
            r_rdata <= r_mem[idx];
        end
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi4_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi4_sram_responder
// Description : AXI4 INCR-burst responder over a word SRAM, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_sram_responder
    import axi4_sram_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    MEM_WORDS  = 65536,
    parameter int                    RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_sram_responder_if.slave bus
);

    localparam int       c_IDX_W  = $clog2(MEM_WORDS);
    localparam int       c_STRB_W = DATA_WIDTH / 8;
    localparam logic [7:0] c_LAT  = 8'(RD_LATENCY - 1);

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 2) < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [c_IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return c_IDX_W'(off >> 2);
    endfunction

    state_t                r_state;
    logic                  r_prio_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [7:0]            r_cnt;
    logic                  r_cfg_err;
    logic                  r_werr;

    logic                  r_arready, r_awready, r_wready;
    logic                  r_rvalid, r_rlast, r_bvalid;
    logic [1:0]            r_rresp, r_bresp;
    logic [ID_WIDTH-1:0]   r_rid, r_bid;

    logic                  w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_cur_err, w_next_err;
    logic                  w_wbeat_last, w_wend, w_wmismatch;
    logic                  w_mem_re;
    logic [c_STRB_W-1:0]   w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_q;

    assign w_ar_hs      = r_arready & bus.arvalid;
    assign w_aw_hs      = r_awready & bus.awvalid;
    assign w_r_hs       = r_rvalid & bus.rready;
    assign w_w_hs       = r_wready & bus.wvalid;
    assign w_next_addr  = r_addr + ADDR_WIDTH'(4);
    assign w_cur_err    = r_cfg_err | ~f_in_range(r_addr);
    assign w_next_err   = r_cfg_err | ~f_in_range(w_next_addr);
    assign w_wbeat_last = (r_beat == r_len);
    assign w_wend       = bus.wlast | w_wbeat_last;
    assign w_wmismatch  = bus.wlast ^ w_wbeat_last;

    // The next read beat is fetched in the handshake cycle so rvalid never drops mid-burst.
    always_comb begin
        w_mem_re   = 1'b0;
        w_mem_we   = '0;
        w_mem_addr = r_addr;
        case (r_state)
            ST_RWAIT: w_mem_re = (r_cnt == 8'd0);
            ST_RDATA: begin
                if (w_r_hs && !r_rlast) begin
                    w_mem_re   = 1'b1;
                    w_mem_addr = w_next_addr;
                end
            end
            ST_WDATA: begin
                if (w_w_hs && !w_cur_err) begin
                    w_mem_we = bus.wstrb;
                end
            end
            default: ;
        endcase
    end

    axi4_sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .re    (w_mem_re),
        .we    (w_mem_we),
        .idx   (f_idx(w_mem_addr)),
        .wdata (bus.wdata),
        .rdata (w_mem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_prio_wr <= 1'b0;
            r_addr    <= '0;
            r_id      <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_cnt     <= '0;
            r_cfg_err <= 1'b0;
            r_werr    <= 1'b0;
            r_arready <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_bresp   <= c_RESP_OKAY;
            r_rid     <= '0;
            r_bid     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_addr    <= bus.araddr;
                        r_id      <= bus.arid;
                        r_rid     <= bus.arid;
                        r_len     <= bus.arlen;
                        r_beat    <= '0;
                        r_cfg_err <= (bus.arsize != c_SIZE_4B) || (bus.arburst != c_BURST_INCR);
                        r_cnt     <= c_LAT;
                        r_state   <= ST_RWAIT;
                    end else if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_addr    <= bus.awaddr;
                        r_id      <= bus.awid;
                        r_len     <= bus.awlen;
                        r_beat    <= '0;
                        r_cfg_err <= (bus.awsize != c_SIZE_4B) || (bus.awburst != c_BURST_INCR);
                        r_werr    <= 1'b0;
                        r_state   <= ST_WDATA;
                    end else if (!r_arready && !r_awready) begin
                        // Priority flips only when both channels contend.
                        if (bus.arvalid && bus.awvalid) begin
                            r_arready <= ~r_prio_wr;
                            r_awready <= r_prio_wr;
                            r_prio_wr <= ~r_prio_wr;
                        end else begin
                            r_arready <= bus.arvalid;
                            r_awready <= bus.awvalid;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= f_resp(w_cur_err);
                        r_rlast  <= (r_len == 8'd0);
                        r_state  <= ST_RDATA;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_beat  <= r_beat + 8'd1;
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                            r_rresp <= f_resp(w_next_err);
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_w_hs) begin
                        if (w_wend) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= f_resp(r_werr | w_cur_err | w_wmismatch);
                            r_bid    <= r_id;
                            r_state  <= ST_WRESP;
                        end else begin
                            r_addr <= w_next_addr;
                            r_beat <= r_beat + 8'd1;
                            r_werr <= r_werr | w_cur_err;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bus.bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.arready = r_arready;
    assign bus.awready = r_awready;
    assign bus.wready  = r_wready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rlast   = r_rlast;
    assign bus.rresp   = r_rresp;
    assign bus.rid     = r_rid;
    assign bus.rdata   = (r_rvalid && r_rresp == c_RESP_OKAY) ? w_mem_q : '0;
    assign bus.bvalid  = r_bvalid;
    assign bus.bresp   = r_bresp;
    assign bus.bid     = r_bid;

endmodule
`default_nettype wire

// File: tb/tb_axi4_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_sram_responder
// Description : Directed table-driven bench for the AXI4 SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_sram_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    axi4_sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_sram_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ID_WIDTH   (4),
        .BASE_ADDR  (32'h8000_0000),
        .MEM_WORDS  (65536),
        .RD_LATENCY (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic [31:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id   [256];
    int          rd_nb, rd_lat, rd_bubbles, rd_unstable;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return {14'd0, bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                bus.rlast, bus.rdata, bus.rresp, bus.rid, bus.bresp, bus.bid};
    endfunction

    function automatic logic sig(input int w);
        logic v;
        case (w)
            0:       v = bus.arready;
            1:       v = bus.awready;
            2:       v = bus.wready;
            3:       v = bus.rvalid;
            4:       v = bus.bvalid;
            default: v = bus.arready | bus.awready;
        endcase
        return v;
    endfunction

    task automatic wait_sig(input int w, input string nm);
        int k = 0;
        while (!sig(w) && k < 50) begin
            tick();
            k++;
        end
        if (!sig(w)) begin
            n_total++;
            $display("FAIL %s: no response after %0d cycles, required within 50", nm, k);
        end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [2:0] size);
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        wait_sig(0, "arready");
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic r_phase(input logic [7:0] len, input logic toggle);
        logic        stall;
        logic [38:0] snap;
        int          guard;
        rd_nb = 0; rd_bubbles = 0; rd_unstable = 0; rd_lat = 0;
        snap = '0;
        bus.rready = ~toggle;
        do begin
            tick();
            rd_lat++;
        end while (!bus.rvalid && rd_lat < 50);
        guard = 0;
        while (bus.rvalid && rd_nb <= int'(len) && guard < 2000) begin
            stall = 1'b0;
            if (bus.rready) begin
                rd_data[rd_nb] = bus.rdata;
                rd_resp[rd_nb] = bus.rresp;
                rd_last[rd_nb] = bus.rlast;
                rd_id[rd_nb]   = bus.rid;
                rd_nb++;
            end else begin
                stall = 1'b1;
                snap  = {bus.rdata, bus.rresp, bus.rid, bus.rlast};
            end
            tick();
            if (stall && snap !== {bus.rdata, bus.rresp, bus.rid, bus.rlast}) rd_unstable++;
            if (!bus.rvalid && rd_nb <= int'(len)) rd_bubbles++;
            if (toggle) bus.rready = ~bus.rready;
            guard++;
        end
        if (rd_nb != int'(len) + 1) begin
            n_total++;
            $display("FAIL r_beats: got %0d beats, expected %0d", rd_nb, int'(len) + 1);
        end
        bus.rready = 1'b0;
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        bus.awaddr  = addr;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awsize  = 3'b010;
        bus.awburst = 2'b01;
        bus.awvalid = 1'b1;
        wait_sig(1, "awready");
        tick();
        bus.awvalid = 1'b0;
    endtask

    // no_last=1 never raises wlast, to exercise a missing wlast.
    task automatic w_phase(input int nbeats, input logic [31:0] data0,
                           input logic [3:0] strb, input logic no_last);
        for (int i = 0; i < nbeats; i++) begin
            bus.wdata  = data0 + 32'(i);
            bus.wstrb  = strb;
            bus.wlast  = !no_last && (i == nbeats - 1);
            bus.wvalid = 1'b1;
            wait_sig(2, "wready");
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic b_phase();
        bus.bready = 1'b1;
        wait_sig(4, "bvalid");
        b_resp = bus.bresp;
        b_id   = bus.bid;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic collide(input logic [31:0] wdata, output logic ar_won);
        bus.araddr = 32'h8000_0008; bus.arid = 4'h6; bus.arlen = 8'd0;
        bus.arsize = 3'b010;        bus.arburst = 2'b01;
        bus.awaddr = 32'h8000_0008; bus.awid = 4'h9; bus.awlen = 8'd0;
        bus.awsize = 3'b010;        bus.awburst = 2'b01;
        bus.arvalid = 1'b1;
        bus.awvalid = 1'b1;
        wait_sig(5, "collide_ready");
        ar_won = bus.arready;
        check("collide_one_ready", {63'd0, bus.arready ^ bus.awready}, 64'd1);
        if (ar_won) begin
            ar_phase(32'h8000_0008, 4'h6, 8'd0, 3'b010);
            r_phase(8'd0, 1'b0);
            aw_phase(32'h8000_0008, 4'h9, 8'd0);
            w_phase(1, wdata, 4'hF, 1'b0);
            b_phase();
        end else begin
            aw_phase(32'h8000_0008, 4'h9, 8'd0);
            w_phase(1, wdata, 4'hF, 1'b0);
            b_phase();
            ar_phase(32'h8000_0008, 4'h6, 8'd0, 3'b010);
            r_phase(8'd0, 1'b0);
        end
    endtask

    vec_t vecs [14];
    logic won;

    initial begin
        bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = 3'b010; bus.arburst = 2'b01;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        vecs[0]  = '{1'b1, 32'h8000_0000, 4'h3, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0000, 4'h5, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h8000_0000, 4'h1, 32'h0000_AB00, 4'h2, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h8000_0000, 4'h2, 32'h0,         4'h0, 2'b00, 32'hDEAD_ABEF};
        vecs[4]  = '{1'b1, 32'h8000_0006, 4'h4, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 32'h8000_0004, 4'h7, 32'h0,         4'h0, 2'b00, 32'h1234_5678};
        vecs[6]  = '{1'b1, 32'h8000_0004, 4'h8, 32'hAA00_00BB, 4'h9, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h8000_0007, 4'h9, 32'h0,         4'h0, 2'b00, 32'hAA34_56BB};
        vecs[8]  = '{1'b0, 32'h7FFF_FFFC, 4'hA, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 32'h8004_0000, 4'hB, 32'hCAFE_F00D, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_0000, 4'hC, 32'h0,         4'h0, 2'b00, 32'hDEAD_ABEF};
        vecs[11] = '{1'b1, 32'h8003_FFFC, 4'hD, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h8003_FFFC, 4'hE, 32'h0,         4'h0, 2'b00, 32'h1122_3344};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         4'h0, 2'b10, 32'h0};

        tick();
        tick();
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_no_ready", outs(), 64'd0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                aw_phase(vecs[i].addr, vecs[i].id, 8'd0);
                w_phase(1, vecs[i].data, vecs[i].strb, 1'b0);
                b_phase();
                check($sformatf("vec%0d_bresp", i), {62'd0, b_resp}, {62'd0, vecs[i].exp_resp});
                check($sformatf("vec%0d_bid", i), {60'd0, b_id}, {60'd0, vecs[i].id});
            end else begin
                ar_phase(vecs[i].addr, vecs[i].id, 8'd0, 3'b010);
                r_phase(8'd0, 1'b0);
                check($sformatf("vec%0d_rdata", i), {32'd0, rd_data[0]}, {32'd0, vecs[i].exp_rdata});
                check($sformatf("vec%0d_rresp", i), {62'd0, rd_resp[0]}, {62'd0, vecs[i].exp_resp});
                check($sformatf("vec%0d_rlast", i), {63'd0, rd_last[0]}, 64'd1);
                check($sformatf("vec%0d_rid", i), {60'd0, rd_id[0]}, {60'd0, vecs[i].id});
            end
        end

        // 4-beat burst, read back with rready held and then toggled
        aw_phase(32'h8000_0010, 4'h2, 8'd3);
        w_phase(4, 32'hA0A0_0000, 4'hF, 1'b0);
        b_phase();
        check("burst_w_bresp", {62'd0, b_resp}, 64'd0);
        ar_phase(32'h8000_0010, 4'h3, 8'd3, 3'b010);
        r_phase(8'd3, 1'b0);
        check("burst_latency", 64'(rd_lat), 64'd3);
        check("burst_bubbles", 64'(rd_bubbles), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("burst_data%0d", i), {32'd0, rd_data[i]}, {32'd0, 32'hA0A0_0000 + 32'(i)});
            check($sformatf("burst_last%0d", i), {63'd0, rd_last[i]}, {63'd0, i == 3});
        end
        ar_phase(32'h8000_0010, 4'h4, 8'd3, 3'b010);
        r_phase(8'd3, 1'b1);
        check("toggle_stable", 64'(rd_unstable), 64'd0);
        check("toggle_beats", 64'(rd_nb), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("toggle_data%0d", i), {32'd0, rd_data[i]}, {32'd0, 32'hA0A0_0000 + 32'(i)});
        end

        // Burst crossing the end of memory
        aw_phase(32'h8003_FFFC, 4'h5, 8'd1);
        w_phase(2, 32'h7777_0000, 4'hF, 1'b0);
        b_phase();
        check("cross_bresp", {62'd0, b_resp}, 64'd2);
        ar_phase(32'h8003_FFFC, 4'h5, 8'd1, 3'b010);
        r_phase(8'd1, 1'b0);
        check("cross_resp0", {62'd0, rd_resp[0]}, 64'd0);
        check("cross_data0", {32'd0, rd_data[0]}, 64'h7777_0000);
        check("cross_resp1", {62'd0, rd_resp[1]}, 64'd2);
        check("cross_data1", {32'd0, rd_data[1]}, 64'd0);

        // Unsupported arsize errors every beat
        ar_phase(32'h8000_0000, 4'h1, 8'd1, 3'b011);
        r_phase(8'd1, 1'b0);
        check("badsize_resp0", {62'd0, rd_resp[0]}, 64'd2);
        check("badsize_resp1", {62'd0, rd_resp[1]}, 64'd2);
        check("badsize_data0", {32'd0, rd_data[0]}, 64'd0);

        // wlast early, then wlast missing
        aw_phase(32'h8000_0040, 4'h2, 8'd3);
        w_phase(2, 32'h5000_0000, 4'hF, 1'b0);
        b_phase();
        check("early_wlast_bresp", {62'd0, b_resp}, 64'd2);
        ar_phase(32'h8000_0040, 4'h2, 8'd0, 3'b010);
        r_phase(8'd0, 1'b0);
        check("early_wlast_data", {32'd0, rd_data[0]}, 64'h5000_0000);
        aw_phase(32'h8000_0050, 4'h3, 8'd0);
        w_phase(1, 32'h0000_0066, 4'hF, 1'b1);
        b_phase();
        check("missing_wlast_bresp", {62'd0, b_resp}, 64'd2);
        check("missing_wlast_bid", {60'd0, b_id}, 64'd3);

        // Reset in the middle of a read burst, then of a write burst
        ar_phase(32'h8000_0010, 4'h7, 8'd7, 3'b010);
        bus.rready = 1'b1;
        wait_sig(3, "midrd_rvalid");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrd_reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        bus.rready = 1'b0;
        tick();
        aw_phase(32'h8000_0060, 4'h8, 8'd3);
        bus.wdata = 32'h1111_1111; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        tick();
        rst = 1'b1;
        bus.wvalid = 1'b0;
        tick();
        check("midwr_reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        tick();
        ar_phase(32'h8000_0000, 4'h1, 8'd0, 3'b010);
        r_phase(8'd0, 1'b0);
        check("sram_kept_after_reset", {32'd0, rd_data[0]}, 64'hDEAD_ABEF);

        // Collisions after reset: read wins first, write wins next
        collide(32'h0BAD_F00D, won);
        check("collide1_read_first", {63'd0, won}, 64'd1);
        collide(32'h0C0F_FEE0, won);
        check("collide2_write_first", {63'd0, won}, 64'd0);
        check("collide2_read_sees_write", {32'd0, rd_data[0]}, 64'h0C0F_FEE0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
